// File: rtl/stc0_stim_gen_if.sv
// Simple write bus carrying register and ingress writes into the stimulus generator.
// One word-addressed write per cycle while WriteDataValid is high.
interface stc0_stim_gen_if;
    logic [23:2] WriteAddr;
    logic [31:0] WriteData;
    logic        WriteDataValid;

    modport master (output WriteAddr, output WriteData, output WriteDataValid);
    modport slave  (input WriteAddr, input WriteData, input WriteDataValid);
endinterface

// File: rtl/stc0_stim_gen.sv
// Multi-channel stimulus generator: each channel emits bus-written ingress samples, an LFSR,
// a ramp or zero, paced by a stride counter and terminated by an iteration count.
module stc0_stim_gen #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned STRIDE_W    = 8,
    parameter int unsigned ITER_W      = 32,
    parameter logic [11:0] BASE_REGION = 12'h000
) (
    input  logic                           Clk,
    input  logic                           ARstN,
    stc0_stim_gen_if.slave                 bus,
    output logic [NUM_CH*2*DATA_WIDTH-1:0] Egress,
    output logic [NUM_CH-1:0]              EgressValid,
    output logic                           Busy,
    output logic                           Done,
    output logic [ITER_W-1:0]              IterCount
);
    localparam int unsigned EgW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} stateT;

    stateT               state;
    logic                iterSrc;
    logic [STRIDE_W-1:0] strideReg;
    logic [STRIDE_W-1:0] strideCnt;
    logic [STRIDE_W-1:0] strideLast;
    logic [ITER_W-1:0]   iterReg;
    logic [ITER_W-1:0]   iterNext;
    logic [2*NUM_CH-1:0] srcSel;
    logic [31:0]         seed    [NUM_CH];
    logic [31:0]         gen     [NUM_CH];
    logic [31:0]         stepped [NUM_CH];
    logic [31:0]         loadVal [NUM_CH];
    logic [31:0]         seed0Loaded;

    logic                hit;
    logic [11:0]         offset;
    logic [2:0]          regCh;
    logic [NUM_CH-1:0]   chSel;
    logic                wrCtrl, wrStride, wrIter, wrSrcSel, wrSeed, wrIngress;
    logic                startReq, abortReq, update, iterInc;

    function automatic logic [31:0] lfsrStep(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    always_comb begin
        hit       = bus.WriteDataValid && (bus.WriteAddr[23:12] == BASE_REGION);
        offset    = {bus.WriteAddr[11:2], 2'b00};
        regCh     = offset[4:2];
        wrCtrl    = hit && (offset == 12'h000);
        wrStride  = hit && (offset == 12'h004);
        wrIter    = hit && (offset == 12'h008);
        wrSrcSel  = hit && (offset == 12'h00C);
        wrSeed    = hit && (offset[11:5] == 7'd2);
        wrIngress = hit && (offset[11:5] == 7'd4);
        // ABORT outranks START when both arrive in one CTRL write
        abortReq  = wrCtrl && bus.WriteData[2];
        startReq  = wrCtrl && bus.WriteData[0] && !bus.WriteData[2];

        chSel = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            chSel[ch]   = (32'(regCh) == ch);
            loadVal[ch] = (srcSel[2*ch +: 2] == 2'd1 && seed[ch] == 32'd0) ? 32'd1 : seed[ch];
            unique case (srcSel[2*ch +: 2])
                2'd1:    stepped[ch] = lfsrStep(gen[ch]);
                2'd2:    stepped[ch] = gen[ch] + 32'd1;
                default: stepped[ch] = gen[ch];
            endcase
        end

        strideLast = (strideReg == '0) ? '0 : strideReg - STRIDE_W'(1);
        update     = (state == StRun) && (strideCnt == strideLast) && !abortReq;
        iterNext   = IterCount + ITER_W'(1);
        iterInc    = iterSrc ? (stepped[0] == seed0Loaded) : 1'b1;
    end

    always_ff @(posedge Clk or negedge ARstN) begin
        if (!ARstN) begin
            state       <= StIdle;
            iterSrc     <= 1'b0;
            strideReg   <= '0;
            strideCnt   <= '0;
            iterReg     <= '0;
            srcSel      <= '0;
            seed0Loaded <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                seed[ch] <= '0;
                gen[ch]  <= '0;
            end
            Egress      <= '0;
            EgressValid <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            IterCount   <= '0;
        end else begin
            EgressValid <= '0;
            Done        <= 1'b0;

            if (!Busy) begin
                if (wrCtrl)   iterSrc   <= bus.WriteData[1];
                if (wrStride) strideReg <= bus.WriteData[STRIDE_W-1:0];
                if (wrIter)   iterReg   <= bus.WriteData[ITER_W-1:0];
                if (wrSrcSel) srcSel    <= bus.WriteData[2*NUM_CH-1:0];
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    if (wrSeed && chSel[ch]) seed[ch] <= bus.WriteData;
                end
            end

            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (wrIngress && chSel[ch] && srcSel[2*ch +: 2] == 2'd0) begin
                    Egress[ch*EgW +: EgW] <= bus.WriteData[EgW-1:0];
                    EgressValid[ch]       <= 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (startReq) begin
                        state <= StLoad;
                        Busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) gen[ch] <= loadVal[ch];
                    seed0Loaded <= loadVal[0];
                    strideCnt   <= '0;
                    IterCount   <= '0;
                    if (abortReq) begin
                        state <= StIdle;
                        Busy  <= 1'b0;
                    end else begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (abortReq) begin
                        state <= StIdle;
                        Busy  <= 1'b0;
                    end else if (update) begin
                        strideCnt <= '0;
                        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                            if (srcSel[2*ch +: 2] != 2'd0) begin
                                Egress[ch*EgW +: EgW] <=
                                    (srcSel[2*ch +: 2] == 2'd3) ? '0 : gen[ch][EgW-1:0];
                                EgressValid[ch] <= 1'b1;
                                gen[ch]         <= stepped[ch];
                            end
                        end
                        if (iterInc) begin
                            IterCount <= iterNext;
                            // ITERATIONS of zero never matches, so the run continues until ABORT
                            if (iterReg != '0 && iterNext == iterReg) begin
                                state <= StDone;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end
                        end
                    end else begin
                        strideCnt <= strideCnt + STRIDE_W'(1);
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule
